// File: rtl/sram_read_check.sv
// ============================================================================
// Module      : sram_read_check
// Description : Streams pipelined reads over the SSRAM wrapper read port and
//               compares each word against the shared address-derived pattern.
//               Optional macro SRAM_READ_CHECK_STOP_ON_ERR_EN ends the pass at
//               the first mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_read_check #(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 32,
    parameter int NUM_WORDS    = 1048576,
    parameter int READ_LATENCY = 2,
    parameter int ERR_W        = 16
) (
    input  logic              CLOCK,
    input  logic              RST,
    input  logic              start,
    input  logic [DATA_W-1:0] bitMask,
    output logic              ren,
    output logic [ADDR_W-1:0] rAddr,
    input  logic [DATA_W-1:0] rData,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [ADDR_W:0] C_LAST_ADDR = (ADDR_W + 1)'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic                     start_q, start_d;
    logic                     ren_q, ren_d;
    logic [ADDR_W:0]          cnt_q, cnt_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     pass_q, pass_d;
    logic [ERR_W-1:0]         err_count_q, err_count_d;
    logic [ADDR_W-1:0]        first_err_addr_q, first_err_addr_d;
    logic [READ_LATENCY-1:0]  pipe_vld_q, pipe_vld_d;
    logic [ADDR_W-1:0]        pipe_addr_q [READ_LATENCY];
    logic [ADDR_W-1:0]        pipe_addr_d [READ_LATENCY];

    logic                     w_start_edge;
    logic                     w_head_vld;
    logic [ADDR_W-1:0]        w_head_addr;
    logic                     w_mismatch;

    // Low ADDR_W bits carry the address, the next ADDR_W bits its complement,
    // repeating as needed to fill DATA_W.
    function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w[i] = (((i / ADDR_W) % 2) == 1) ? ~a[i % ADDR_W] : a[i % ADDR_W];
        end
        return w;
    endfunction

    assign w_start_edge = start & ~start_q;
    assign w_head_vld   = pipe_vld_q[READ_LATENCY-1];
    assign w_head_addr  = pipe_addr_q[READ_LATENCY-1];
    assign w_mismatch   = w_head_vld &&
                          ((rData & bitMask) != (exp_word(w_head_addr) & bitMask));

    always_comb begin
        state_d          = state_q;
        start_d          = start;
        ren_d            = ren_q;
        cnt_d            = cnt_q;
        busy_d           = busy_q;
        done_d           = done_q;
        pass_d           = pass_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;

        // Each cycle the issued request (if any) enters the tail of the pipe.
        pipe_vld_d[0]  = ren_q;
        pipe_addr_d[0] = cnt_q[ADDR_W-1:0];
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
        end

        if (w_mismatch) begin
            if (err_count_q != '1) begin
                err_count_d = err_count_q + ERR_W'(1);
            end
            if (err_count_q == '0) begin
                first_err_addr_d = w_head_addr;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (w_start_edge) begin
                    err_count_d      = '0;
                    first_err_addr_d = '0;
                    pass_d           = 1'b0;
                    done_d           = 1'b0;
                    busy_d           = 1'b1;
                    ren_d            = 1'b1;
                    cnt_d            = '0;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cnt_q == C_LAST_ADDR) begin
                    ren_d   = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + (ADDR_W + 1)'(1);
                end
            end
            S_DRAIN: begin
                // The final compare lands in the same edge that closes the pass.
                if (pipe_vld_d == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_count_d == '0);
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef SRAM_READ_CHECK_STOP_ON_ERR_EN
        if (w_mismatch) begin
            ren_d      = 1'b0;
            pipe_vld_d = '0;
            state_d    = S_DONE;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            pass_d     = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLOCK or posedge RST) begin
        if (RST) begin
            state_q          <= S_IDLE;
            start_q          <= 1'b0;
            ren_q            <= 1'b0;
            cnt_q            <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            pipe_vld_q       <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_addr_q[i] <= '0;
            end
        end else begin
            state_q          <= state_d;
            start_q          <= start_d;
            ren_q            <= ren_d;
            cnt_q            <= cnt_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            pipe_vld_q       <= pipe_vld_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_addr_q[i] <= pipe_addr_d[i];
            end
        end
    end

    assign ren            = ren_q;
    assign rAddr          = cnt_q[ADDR_W-1:0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;

endmodule

`default_nettype wire

// File: doc/sram_read_check.md
Name: sram_read_check

Overview:
- Read-back verifier for the SSRAM path and the counterpart of sram_write.
- After sram_write fills the SSRAM through sram_wrapper, this block streams reads over the same wrapper read port (ren/rAddr/rData) and compares every word against the shared test pattern.
- It reports pass/fail, an error count and the first failing address; the results drive LEDs in the top level.
- Reads are pipelined: one request per cycle, with the wrapper's fixed read latency tracked by an address shift pipe.

Parameters:
- ADDR_W, 20, width of rAddr and of the word address space.
- DATA_W, 32, width of rData and bitMask.
- NUM_WORDS, 1048576, words checked, starting at address 0; legal range 1..2^ADDR_W.
- READ_LATENCY, 2, cycles from a ren=1 edge to valid rData; legal range 1..8.
- ERR_W, 16, width of the error counter.

Ports:
- CLOCK  in  1  system clock, same as sram_wrapper CLOCK.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  level input, already synchronized; a rising edge launches a check pass.
- bitMask  in  DATA_W  mask applied to both expected and read data before the compare.
- ren  out  1  read request to sram_wrapper.
- rAddr  out  ADDR_W  read address to sram_wrapper.
- rData  in  DATA_W  read data from sram_wrapper, valid READ_LATENCY cycles after the request.
- busy  out  1  high from launch until done.
- done  out  1  pass complete; held in DONE.
- pass  out  1  valid when done=1; 1 means no mismatches.
- err_count  out  ERR_W  mismatch count; saturates at all-ones.
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none.

Behaviour:
- Reset (RST=1, asynchronous):
  - State goes to IDLE.
  - ren=0, rAddr=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0.
  - Pipe valids are cleared and the start edge register is cleared.
- Expected pattern (shared with sram_write):
  - exp(a) = {~a[11:0], a[19:0]} for DATA_W=32, ADDR_W=20.
  - Mismatch when (rData & bitMask) != (exp(a) & bitMask).
- Start edge:
  - Detected as start & ~start_q.
  - Edges in any state other than IDLE are ignored.
- IDLE:
  - On a start edge: clear err_count, first_err_addr, pass and done; set busy=1; go to ISSUE.
- ISSUE:
  - ren=1, with rAddr = 0, 1, 2, ... advancing by one per cycle.
  - Each issued address enters the pipe with valid=1.
  - After the cycle carrying address NUM_WORDS-1, go to DRAIN; ren=0 from the next cycle.
  - The address counter is ADDR_W+1 bits wide, so NUM_WORDS=2^ADDR_W terminates without wrapping.
- Pipe:
  - Depth is READ_LATENCY.
  - At each edge, a valid pipe head compares rData against exp(head address).
  - On a mismatch, err_count increments, saturating.
  - first_err_addr captures the head address only on the first mismatch of the pass.
- DRAIN:
  - ren=0; wait until the pipe is empty, then go to DONE.
- DONE:
  - done=1, busy=0, pass=(err_count==0).
  - Stay while start=1; go to IDLE when start=0.
  - done, pass and the counters hold their values in IDLE until the next launch.
- Timing: with the first ren=1 at cycle T, done rises at cycle T+NUM_WORDS+READ_LATENCY.
- Simultaneous events: a mismatch in the final compare cycle is counted before done and pass are evaluated.
- Reset mid-pass: all state and outputs return to reset values immediately; there is no partial result.
- Wrapper contract: rData is sampled only at pipe-valid slots; rData values outside those slots are ignored.

Optional Feature:
- Macro: SRAM_READ_CHECK_STOP_ON_ERR_EN.
- Defined:
  - The first mismatch forces ren=0 in the next cycle, discards in-flight pipe entries, and goes to DONE.
  - err_count is then 1, pass=0, and first_err_addr holds the failing address.
- Undefined: the full range is always checked and all mismatches are counted.

Test Plan:
- All reads correct: NUM_WORDS=8, READ_LATENCY=2, bitMask=FFFFFFFF, model returns exp(a); raise start → ren high 8 cycles with rAddr 0..7, done at T+10, pass=1, err_count=0, first_err_addr=0.
- Corrupted words: model corrupts addr 3 (rData=0) and addr 6 → pass=0, err_count=2, first_err_addr=3.
- Masked compare: bitMask=0000FFFF, model flips bit 31 at every address → pass=1, err_count=0.
- Restart behaviour:
  - Hold start=1 after done → stays in DONE with no new reads.
  - Drop start, then raise it → second pass runs and counters restart from 0.
  - A start edge while busy is ignored.
- Reset mid-pass: assert RST at rAddr=4 → ren, busy and done go to 0 immediately; after release, the next start edge performs a full clean pass of 8 reads.
- Stop on error: build with SRAM_READ_CHECK_STOP_ON_ERR_EN and corrupt addr 2 → ren drops after the compare of addr 2, done=1, err_count=1, first_err_addr=2; without the macro, all 8 addresses are read.
